swap_initiator: RTL and testbench

Initiator side of the `w`/`done` swap handshake. Accepts swap requests from the control logic, holds them in a pending counter, and issues one `w` pulse per request to the three-register swap engine. After each pulse it waits for the engine's `done` to fall and rise again, counts completed swaps, and flags engine hangs and request overflow. It sits between the control FSM and the swap engine, clocked by the same `ck`.

---
 rtl/swap_initiator.sv | 149 ++++++++++++++
 tb/tb_swap_initiator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_initiator.sv
// swap_initiator
// Initiator side of the w/done swap handshake. Queues swap requests from the
// control logic in a pending counter and sends one single-cycle w strobe per
// request to the swap engine. After each strobe it waits for the engine's done
// to fall and rise again. It counts completed swaps, and it flags request
// overflow and (optionally) engine hangs.
//
// Optional feature macro: SWAP_INITIATOR_TIMEOUT_EN
//   defined   : each handshake phase has a timer. Once the timer reaches
//               TIMEOUT the request is dropped and timeout_err is set.
//   undefined : there is no timer, timeout_err is tied low, and the wait
//               phases wait indefinitely.
//
// Ports
//   ck          in   clock, rising edge
//   rst         in   synchronous active-high reset
//   req         in   one swap request per cycle high
//   req_ready   out  pending < DEPTH
//   w           out  swap strobe to engine (ISSUE state only)
//   done        in   engine idle flag (high = idle)
//   busy        out  FSM not idle
//   pending     out  queued requests not yet completed or aborted
//   swap_count  out  completed swaps, wraps modulo 2^CNT_W
//   overflow    out  sticky: request arrived while full
//   timeout_err out  sticky: handshake phase exceeded TIMEOUT
module swap_initiator #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             req,
    output logic             req_ready,
    output logic             w,
    input  logic             done,
    output logic             busy,
    output logic [3:0]       pending,
    output logic [CNT_W-1:0] swap_count,
    output logic             overflow,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   tmo;       // phase timer has reached its limit
    logic   complete;  // engine finished the in-flight swap this cycle
    logic   abort;     // in-flight swap dropped on timeout this cycle
    logic   dec;

`ifdef SWAP_INITIATOR_TIMEOUT_EN
    logic [7:0] timer;

    assign tmo = (timer == 8'(TIMEOUT));

    // The timer restarts at the start of each phase: it clears in ISSUE and
    // again on the WAIT_LOW -> WAIT_HIGH transition.
    always_ff @(posedge ck) begin
        if (rst)
            timer <= '0;
        else if (state == ISSUE || (state == WAIT_LOW && !done))
            timer <= '0;
        else if (state == WAIT_LOW || state == WAIT_HIGH)
            timer <= timer + 8'd1;
    end

    always_ff @(posedge ck) begin
        if (rst)
            timeout_err <= 1'b0;
        else if (abort)
            timeout_err <= 1'b1;
    end
`else
    logic unused_timeout;

    assign tmo            = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = ^8'(TIMEOUT);
`endif

    // If the engine responds in the same cycle the timer expires, the
    // response is taken and the request is not dropped.
    assign complete = (state == WAIT_HIGH) && done;
    assign abort    = tmo && (((state == WAIT_LOW) && done) ||
                              ((state == WAIT_HIGH) && !done));
    assign dec      = complete || abort;

    // State register
    always_ff @(posedge ck) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pending != 4'd0 && done) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_LOW;
            WAIT_LOW:  if (!done) state_nxt = WAIT_HIGH;
                       else if (tmo) state_nxt = IDLE;
            WAIT_HIGH: if (done || tmo) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the registered state only. This keeps
    // done from reaching w through any combinational path.
    always_comb begin
        w    = (state == ISSUE);
        busy = (state != IDLE);
    end

    assign req_ready = (pending < 4'(DEPTH));

    // Pending queue depth. A request arriving together with a completion or
    // abort leaves the depth unchanged, even when full, and is not counted
    // as an overflow.
    always_ff @(posedge ck) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (req && dec) begin
            pending  <= pending;
        end else if (dec) begin
            pending  <= pending - 4'd1;
        end else if (req && req_ready) begin
            pending  <= pending + 4'd1;
        end else if (req) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (rst)
            swap_count <= '0;
        else if (complete)
            swap_count <= swap_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_swap_initiator.sv
module tb_swap_initiator;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic rst = 1'b1;
    logic req = 1'b0;
    logic hang = 1'b0;

    // DUT 1: default parameters. DUT 2: CNT_W=2 to exercise the counter wrap.
    logic       done1 = 1'b1, done2 = 1'b1;
    logic       rdy1, w1, busy1, ov1, to1;
    logic       rdy2, w2, busy2, ov2, to2;
    logic [3:0] pend1, pend2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    swap_initiator u_dut1 (
        .ck(ck), .rst(rst), .req(req), .req_ready(rdy1), .w(w1), .done(done1),
        .busy(busy1), .pending(pend1), .swap_count(cnt1), .overflow(ov1),
        .timeout_err(to1)
    );

    swap_initiator #(.CNT_W(2)) u_dut2 (
        .ck(ck), .rst(rst), .req(req), .req_ready(rdy2), .w(w2), .done(done2),
        .busy(busy2), .pending(pend2), .swap_count(cnt2), .overflow(ov2),
        .timeout_err(to2)
    );

    // Compliant engine models. done drops the cycle after w is sampled and
    // stays low for 3 cycles. The three registers of engine 1 rotate when
    // a swap completes. In hang mode the engines ignore w.
    int lc1 = 0, lc2 = 0;
    int r0 = 1, r1 = 2, r2 = 3;

    always @(posedge ck) begin
        if (rst) begin
            done1 <= 1'b1; lc1 <= 0; r0 <= 1; r1 <= 2; r2 <= 3;
            done2 <= 1'b1; lc2 <= 0;
        end else if (!hang) begin
            if (w1) begin done1 <= 1'b0; lc1 <= 3; end
            else if (lc1 > 1) lc1 <= lc1 - 1;
            else if (lc1 == 1) begin
                lc1 <= 0; done1 <= 1'b1; r0 <= r1; r1 <= r2; r2 <= r0;
            end
            if (w2) begin done2 <= 1'b0; lc2 <= 3; end
            else if (lc2 > 1) lc2 <= lc2 - 1;
            else if (lc2 == 1) begin lc2 <= 0; done2 <= 1'b1; end
        end
    end

    int n_run = 0, n_fail = 0;

    // Transaction-level reference model for a compliant engine. Each accepted
    // request gets an issue cycle. An accepted request is visible one cycle
    // later, and an issue needs one idle cycle first, so an issue falls 2
    // cycles after acceptance at the earliest. A swap occupies 6 cycles, so
    // an issue falls 6 cycles after the previous issue at the earliest. The
    // completion is visible 5 cycles after the issue.
    int m_iss[$];
    bit m_ov;
    int m_c;
    int e_pend, e_cnt;
    bit e_w, e_busy, e_rdy;

    task automatic model_eval();
        e_pend = 0; e_cnt = 0; e_w = 1'b0; e_busy = 1'b0;
        foreach (m_iss[i]) begin
            if (m_iss[i] + 5 <= m_c) e_cnt++;
            else e_pend++;
            if (m_iss[i] == m_c) e_w = 1'b1;
            if (m_iss[i] <= m_c && m_c < m_iss[i] + 5) e_busy = 1'b1;
        end
        e_rdy = (e_pend < 4);
    endtask

    task automatic model_req(input bit r);
        bit cmp_now;
        int last, nxt;
        cmp_now = 1'b0;
        foreach (m_iss[i]) if (m_iss[i] + 5 == m_c + 1) cmp_now = 1'b1;
        if (r) begin
            if (e_pend < 4 || cmp_now) begin
                last = (m_iss.size() == 0) ? -100 : m_iss[$];
                nxt  = (m_c + 2 > last + 6) ? m_c + 2 : last + 6;
                m_iss.push_back(nxt);
            end else begin
                m_ov = 1'b1;
            end
        end
        m_c++;
    endtask

    task automatic step(input bit r);
        req = r;
        @(posedge ck); #1;
        req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0;
        repeat (2) begin @(posedge ck); #1; end
        rst = 1'b0;
        m_iss.delete(); m_ov = 1'b0; m_c = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1;
        repeat (2) begin @(posedge ck); #1; end
        n_run++; if (pend1 !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pend1); end
        n_run++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt1); end
        n_run++; if (w1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_w_busy: got %b%b want 00", w1, busy1); end
        n_run++; if (ov1 !== 1'b0 || to1 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", ov1, to1); end
        n_run++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy1); end
        n_run++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_count2: got %0d want 0", cnt2); end
        req = 1'b0;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            model_eval();
            n_run++; if (w1 !== (c == 2)) begin n_fail++; $display("FAIL single_w c=%0d: got %b want %b", c, w1, (c == 2)); end
            n_run++; if (pend1 !== 4'(e_pend)) begin n_fail++; $display("FAIL single_pending c=%0d: got %0d want %0d", c, pend1, e_pend); end
            n_run++; if (busy1 !== e_busy) begin n_fail++; $display("FAIL single_busy c=%0d: got %b want %b", c, busy1, e_busy); end
            if (c == 7) begin
                n_run++; if (cnt1 !== 8'd1 || pend1 !== 4'd0) begin n_fail++; $display("FAIL single_done7: got cnt %0d pend %0d want 1 0", cnt1, pend1); end
            end
            model_req(c == 0);
            step(c == 0);
        end
        n_run++; if (r0 !== 2 || r1 !== 3 || r2 !== 1) begin n_fail++; $display("FAIL single_regs: got %0d/%0d/%0d want 2/3/1", r0, r1, r2); end
    endtask

    task automatic test_burst();
        int npulse, last_p;
        npulse = 0; last_p = -1;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            model_eval();
            n_run++; if (pend1 !== 4'(e_pend)) begin n_fail++; $display("FAIL burst_pending c=%0d: got %0d want %0d", c, pend1, e_pend); end
            n_run++; if (w1 !== e_w) begin n_fail++; $display("FAIL burst_w c=%0d: got %b want %b", c, w1, e_w); end
            if (w1 === 1'b1) begin
                if (last_p >= 0) begin
                    n_run++; if (c - last_p !== 6) begin n_fail++; $display("FAIL burst_spacing: got %0d want 6", c - last_p); end
                end
                npulse++; last_p = c;
            end
            model_req(c < 6);
            step(c < 6);
        end
        n_run++; if (npulse !== 4) begin n_fail++; $display("FAIL burst_pulses: got %0d want 4", npulse); end
        n_run++; if (cnt1 !== 8'd4) begin n_fail++; $display("FAIL burst_count: got %0d want 4", cnt1); end
        n_run++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL burst_overflow: got %b want 1", ov1); end
    endtask

    task automatic test_full_completion();
        bit r;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            model_eval();
            n_run++; if (pend1 !== 4'(e_pend)) begin n_fail++; $display("FAIL full_pending c=%0d: got %0d want %0d", c, pend1, e_pend); end
            if (c == 7) begin
                n_run++; if (pend1 !== 4'd4 || ov1 !== 1'b0) begin n_fail++; $display("FAIL full_net0: got pend %0d ov %b want 4 0", pend1, ov1); end
            end
            r = (c < 4) || (c == 6);
            model_req(r);
            step(r);
        end
    endtask

    task automatic test_random();
        bit r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            model_eval();
            n_run++; if (pend1 !== 4'(e_pend)) begin n_fail++; $display("FAIL rand_pending c=%0d: got %0d want %0d", c, pend1, e_pend); end
            n_run++; if (cnt1 !== 8'(e_cnt)) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, cnt1, e_cnt); end
            n_run++; if (cnt2 !== 2'(e_cnt)) begin n_fail++; $display("FAIL rand_count2 c=%0d: got %0d want %0d", c, cnt2, e_cnt % 4); end
            n_run++; if (w1 !== e_w) begin n_fail++; $display("FAIL rand_w c=%0d: got %b want %b", c, w1, e_w); end
            n_run++; if (busy1 !== e_busy) begin n_fail++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy1, e_busy); end
            n_run++; if (rdy1 !== e_rdy) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, rdy1, e_rdy); end
            n_run++; if (ov1 !== m_ov) begin n_fail++; $display("FAIL rand_overflow c=%0d: got %b want %b", c, ov1, m_ov); end
            r = ($urandom_range(0, 99) < 35);
            model_req(r);
            step(r);
        end
    endtask

    task automatic test_wrap();
        int exp_seq[5];
        int k;
        exp_seq = '{1, 2, 3, 0, 1};
        k = 0;
        do_reset();
        for (int c = 0; c < 34; c++) begin
            if (c == 7 || c == 13 || c == 19 || c == 25 || c == 31) begin
                n_run++; if (cnt2 !== 2'(exp_seq[k])) begin n_fail++; $display("FAIL wrap_count k=%0d: got %0d want %0d", k, cnt2, exp_seq[k]); end
                k++;
            end
            step((c % 6 == 0) && (c < 30));
        end
    endtask

    task automatic test_timeout();
        do_reset();
        hang = 1'b1;
        for (int c = 0; c < 40; c++) begin
`ifdef SWAP_INITIATOR_TIMEOUT_EN
            if (c >= 3 && c <= 18) begin
                n_run++; if (to1 !== 1'b0 || busy1 !== 1'b1 || pend1 !== 4'd1) begin n_fail++; $display("FAIL tmo_wait c=%0d: got to %b busy %b pend %0d want 0 1 1", c, to1, busy1, pend1); end
            end
            if (c == 19 || c == 39) begin
                n_run++; if (to1 !== 1'b1 || pend1 !== 4'd0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL tmo_abort c=%0d: got to %b pend %0d busy %b want 1 0 0", c, to1, pend1, busy1); end
                n_run++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL tmo_count: got %0d want 0", cnt1); end
            end
`else
            if (c >= 3) begin
                n_run++; if (to1 !== 1'b0 || busy1 !== 1'b1 || pend1 !== 4'd1 || w1 !== 1'b0) begin n_fail++; $display("FAIL hang_wait c=%0d: got to %b busy %b pend %0d w %b want 0 1 1 0", c, to1, busy1, pend1, w1); end
            end
`endif
            step(c == 0);
        end
        hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) step(c < 3);
        n_run++; if (pend1 !== 4'd3 || busy1 !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got pend %0d busy %b want 3 1", pend1, busy1); end
        rst = 1'b1;
        @(posedge ck); #1;
        rst = 1'b0;
        n_run++; if (pend1 !== 4'd0 || busy1 !== 1'b0 || w1 !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got pend %0d busy %b w %b want 0 0 0", pend1, busy1, w1); end
        n_run++; if (cnt1 !== 8'd0 || ov1 !== 1'b0 || to1 !== 1'b0 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL mid_reset_misc: got cnt %0d ov %b to %b rdy %b want 0 0 0 1", cnt1, ov1, to1, rdy1); end
        for (int c = 0; c < 10; c++) begin
            n_run++; if (w1 !== 1'b0 || pend1 !== 4'd0) begin n_fail++; $display("FAIL mid_quiet c=%0d: got w %b pend %0d want 0 0", c, w1, pend1); end
            step(1'b0);
        end
        step(1'b1);
        step(1'b0);
        n_run++; if (w1 !== 1'b1) begin n_fail++; $display("FAIL mid_reissue: got w %b want 1", w1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_completion();
        test_random();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
